// File: rtl/inv_mix_columns_seq.sv
// inv_mix_columns_seq
//   Sequential AES InvMixColumns. A 128-bit state is latched as four 32-bit
//   columns. The columns are then transformed in place, COLS_PER_CYCLE columns
//   per clock, by the inverse MixColumns matrix {0e,0b,0d,09}. The finished
//   state is held until the downstream side takes it.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
//   high. The producer holds valid and data until that edge. ready never
//   depends on valid. Here in_ready depends only on the FSM state, and
//   out_valid and result_a* come straight from flops.
//
// Ports
//   clk                   system clock, rising edge
//   rst                   synchronous active-high reset
//   in_valid / in_ready   input handshake
//   in_a0..in_a3          input columns; [31:24] = row 0, [7:0] = row 3
//   out_valid / out_ready output handshake
//   result_a0..result_a3  output columns, same byte order; valid only in DONE
module inv_mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a0,
  input  logic [31:0] in_a1,
  input  logic [31:0] in_a2,
  input  logic [31:0] in_a3,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result_a0,
  output logic [31:0] result_a1,
  output logic [31:0] result_a2,
  output logic [31:0] result_a3
);

  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
      $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // For COLS_PER_CYCLE=4 the step truncates to 0. With one group per state
  // the index never moves off column 0.
  localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
  // This is the first column of the final group. Once it has been processed,
  // every column is done.
  localparam logic [1:0] LAST_IDX = 2'(4 - COLS_PER_CYCLE);

  logic [1:0]  state_q, state_d;
  logic [1:0]  col_idx_q, col_idx_d;
  logic [31:0] cols_q [4];
  logic [31:0] cols_d [4];

  // GF(2^8) doubling modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  // Applies the inverse MixColumns matrix to one column. Row 0 is in the top
  // byte. The x9, xb, xd and xe products are built from a shared
  // x2/x4/x8 doubling chain.
  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] s  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      s[i]  = c[31 - 8*i -: 8];
      x2    = xtime(s[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ s[i];
      mb[i] = x8 ^ x2 ^ s[i];
      md[i] = x8 ^ x4 ^ s[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    cols_d    = cols_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          cols_d    = '{in_a0, in_a1, in_a2, in_a3};
          col_idx_d = 2'd0;
          state_d   = S_BUSY;
        end
      end
      S_BUSY: begin
        // The index sum is 2 bits wide, so it wraps modulo 4.
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
          cols_d[col_idx_q + 2'(g)] = inv_col(cols_q[col_idx_q + 2'(g)]);
        end
        col_idx_d = col_idx_q + COL_STEP;
        if (col_idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      col_idx_q <= 2'd0;
      cols_q    <= '{default: '0};
    end else begin
      state_q   <= state_d;
      col_idx_q <= col_idx_d;
      cols_q    <= cols_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result_a0 = cols_q[0];
  assign result_a1 = cols_q[1];
  assign result_a2 = cols_q[2];
  assign result_a3 = cols_q[3];

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
module tb_inv_mix_columns_seq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] in_a [4];
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic [31:0] res [3][4];

  int tests = 0;
  int fails = 0;
  int lat_tab [3];

  inv_mix_columns_seq #(.COLS_PER_CYCLE(1)) dut_c1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_a0(in_a[0]), .in_a1(in_a[1]), .in_a2(in_a[2]), .in_a3(in_a[3]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .result_a0(res[0][0]), .result_a1(res[0][1]), .result_a2(res[0][2]), .result_a3(res[0][3])
  );

  inv_mix_columns_seq #(.COLS_PER_CYCLE(2)) dut_c2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_a0(in_a[0]), .in_a1(in_a[1]), .in_a2(in_a[2]), .in_a3(in_a[3]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .result_a0(res[1][0]), .result_a1(res[1][1]), .result_a2(res[1][2]), .result_a3(res[1][3])
  );

  inv_mix_columns_seq #(.COLS_PER_CYCLE(4)) dut_c4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_a0(in_a[0]), .in_a1(in_a[1]), .in_a2(in_a[2]), .in_a3(in_a[3]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .result_a0(res[2][0]), .result_a1(res[2][1]), .result_a2(res[2][2]), .result_a3(res[2][3])
  );

  // ---------------- reference models ----------------
  // Generic shift-and-add GF(2^8) multiply.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // Circulant matrix multiply of every column; k = first matrix row.
  function automatic logic [127:0] mat_mul(input logic [127:0] x, input logic [31:0] k);
    logic [127:0] r;
    logic [7:0]   s [4];
    logic [7:0]   kb [4];
    logic [7:0]   acc;
    for (int j = 0; j < 4; j++) kb[j] = k[31 - 8*j -: 8];
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) s[j] = x[127 - 32*c - 8*j -: 8];
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(kb[(j - row + 4) % 4], s[j]);
        r[127 - 32*c - 8*row -: 8] = acc;
      end
    end
    return r;
  endfunction

  // ---------------- driver / check tasks ----------------
  logic [127:0] exp_q [$];
  int           acc_q [$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] get_res(input int d);
    return {res[d][0], res[d][1], res[d][2], res[d][3]};
  endfunction

  task automatic set_in(input logic [127:0] x);
    in_a[0] = x[127:96];
    in_a[1] = x[95:64];
    in_a[2] = x[63:32];
    in_a[3] = x[31:0];
  endtask

  // One full transfer on DUT d: accept, count edges to out_valid, capture result.
  task automatic run_txn(input int d, input logic [127:0] x, output logic [127:0] r, output int lat);
    int n;
    out_ready[d] = 1'b1;
    set_in(x);
    in_valid[d] = 1'b1;
    n = 0;
    while (!in_ready[d] && n < 20) begin
      step();
      n++;
    end
    step();
    in_valid[d] = 1'b0;
    lat = 0;
    while (!out_valid[d] && lat < 20) begin
      step();
      lat++;
    end
    r = get_res(d);
    step();
  endtask

  localparam logic [127:0] V1_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V1_EXP = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V2_IN  = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
  localparam logic [127:0] V2_EXP = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [127:0] r;
    logic [127:0] x;
    int           lat;
    int           e;
    int           n_out;

    lat_tab = '{4, 2, 1};
    rst = 1'b1;
    set_in('0);
    for (int d = 0; d < 3; d++) begin
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b1;
    end
    step();
    step();
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset_in_ready_%0d", d), {127'b0, in_ready[d]}, 128'd1);
      check($sformatf("reset_out_valid_%0d", d), {127'b0, out_valid[d]}, 128'd0);
    end
    rst = 1'b0;
    step();

    // Single vector, one column per cycle
    run_txn(0, V1_IN, r, lat);
    check("v1_result_c1", r, V1_EXP);
    check("v1_latency_c1", 128'(lat), 128'd4);

    // Round-trip vector on all widths
    for (int d = 0; d < 3; d++) begin
      run_txn(d, V2_IN, r, lat);
      check($sformatf("v2_result_dut%0d", d), r, V2_EXP);
      check($sformatf("v2_latency_dut%0d", d), 128'(lat), 128'(lat_tab[d]));
      check($sformatf("v2_fwd_roundtrip_dut%0d", d), mat_mul(r, 32'h02030101), V2_IN);
    end

    // Backpressure on dut0
    out_ready[0] = 1'b0;
    set_in(V1_IN);
    in_valid[0] = 1'b1;
    step();
    in_valid[0] = 1'b0;
    lat = 0;
    while (!out_valid[0] && lat < 20) begin
      step();
      lat++;
    end
    check("bp_latency", 128'(lat), 128'd4);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        set_in(V2_IN);
        in_valid[0] = 1'b1;
      end
      step();
      in_valid[0] = 1'b0;
      check($sformatf("bp_hold_result_%0d", i), get_res(0), V1_EXP);
      check($sformatf("bp_out_valid_%0d", i), {127'b0, out_valid[0]}, 128'd1);
      check($sformatf("bp_in_ready_%0d", i), {127'b0, in_ready[0]}, 128'd0);
    end
    out_ready[0] = 1'b1;
    step();
    check("bp_release_in_ready", {127'b0, in_ready[0]}, 128'd1);
    check("bp_release_out_valid", {127'b0, out_valid[0]}, 128'd0);
    step();
    check("bp_pulse_ignored", {127'b0, in_ready[0]}, 128'd1);

    // Back-to-back with in_valid held high
    exp_q.push_back(V1_EXP);
    exp_q.push_back(V2_EXP);
    set_in(V1_IN);
    in_valid[0] = 1'b1;
    e = 0;
    n_out = 0;
    while (n_out < 2 && e < 40) begin
      if (in_valid[0] && in_ready[0]) acc_q.push_back(e + 1);
      step();
      e++;
      if (acc_q.size() == 1) set_in(V2_IN);
      if (acc_q.size() == 2) in_valid[0] = 1'b0;
      if (out_valid[0] && out_ready[0] && exp_q.size() > 0) begin
        check($sformatf("b2b_result_%0d", n_out), get_res(0), exp_q.pop_front());
        n_out++;
      end
    end
    in_valid[0] = 1'b0;
    check("b2b_outputs_seen", 128'(n_out), 128'd2);
    check("b2b_accepts_seen", 128'(acc_q.size()), 128'd2);
    if (acc_q.size() == 2) check("b2b_accept_spacing", 128'(acc_q[1] - acc_q[0]), 128'd6);
    step();

    // Reset during the second BUSY cycle
    set_in(V1_IN);
    in_valid[0] = 1'b1;
    step();
    in_valid[0] = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_in_ready", {127'b0, in_ready[0]}, 128'd1);
    check("midrst_out_valid", {127'b0, out_valid[0]}, 128'd0);
    run_txn(0, V2_IN, r, lat);
    check("midrst_result", r, V2_EXP);
    check("midrst_latency", 128'(lat), 128'd4);

    // Random states against the models
    for (int i = 0; i < 30; i++) begin
      for (int d = 0; d < 3; d++) begin
        x = {$urandom_range(32'hffffffff, 0), $urandom_range(32'hffffffff, 0),
             $urandom_range(32'hffffffff, 0), $urandom_range(32'hffffffff, 0)};
        run_txn(d, x, r, lat);
        check($sformatf("rand_inv_dut%0d_%0d", d, i), r, mat_mul(x, 32'h0e0b0d09));
        check($sformatf("rand_fwd_dut%0d_%0d", d, i), mat_mul(r, 32'h02030101), x);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
